// File: rtl/status_flags.sv
`default_nettype none
// ============================================================================
// Module   : status_flags
// Purpose  : 6502 processor status register (P). Captures ALU flags under a
//            per-flag mask, executes set/clear instructions, loads P from
//            the data bus, builds the push image and decodes branches.
// Revision : 1.0 - initial release
// ============================================================================
module status_flags #(
  parameter logic RESET_I     = 1'b1,
  parameter int   DELAY_IMASK = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic       alu_overflow,
  input  logic       alu_c_out,
  input  logic [3:0] flag_we,
  input  logic       sc_en,
  input  logic [1:0] sc_sel,
  input  logic       sc_val,
  input  logic       load_en,
  input  logic [7:0] load_data,
  input  logic       int_entry,
  input  logic       push_brk,
  input  logic [1:0] br_sel,
  input  logic       br_sense,
  output logic [7:0] p_push,
  output logic       c_in,
  output logic       bcd,
  output logic       irq_mask,
  output logic       branch_taken
);

  // Stored flags; bits 5 and 4 of P have no storage.
  logic r_n, r_v, r_d, r_i, r_z, r_c;
  logic r_irq_mask;

  logic w_n, w_v, w_d, w_i, w_z, w_c;
  logic w_mask_set;
  logic w_sel_flag;

  // A bus load shadows every other source, including interrupt entry.
  assign w_mask_set = int_entry & ~load_en;

  // Next-state flags: sources applied lowest priority first so later ones win.
  always_comb begin
    w_n = r_n;
    w_v = r_v;
    w_d = r_d;
    w_i = r_i;
    w_z = r_z;
    w_c = r_c;
    if (load_en) begin
      w_n = load_data[7];
      w_v = load_data[6];
      w_d = load_data[3];
      w_i = load_data[2];
      w_z = load_data[1];
      w_c = load_data[0];
    end else begin
      if (flag_we[0]) w_c = alu_c_out;
      if (flag_we[1]) w_z = alu_zero;
      if (flag_we[2]) w_v = alu_overflow;
      if (flag_we[3]) w_n = alu_negative;
      if (sc_en) begin
        case (sc_sel)
          2'd0:    w_c = sc_val;
          2'd1:    w_i = sc_val;
          2'd2:    w_d = sc_val;
          default: w_v = sc_val;
        endcase
      end
      if (int_entry) w_i = 1'b1;
    end
  end

  // Flag storage plus the delayed interrupt mask (interrupt entry bypasses the delay).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_n        <= 1'b0;
      r_v        <= 1'b0;
      r_d        <= 1'b0;
      r_i        <= RESET_I;
      r_z        <= 1'b0;
      r_c        <= 1'b0;
      r_irq_mask <= RESET_I;
    end else begin
      r_n        <= w_n;
      r_v        <= w_v;
      r_d        <= w_d;
      r_i        <= w_i;
      r_z        <= w_z;
      r_c        <= w_c;
      r_irq_mask <= w_mask_set | r_i;
    end
  end

  generate
    if (DELAY_IMASK != 0) begin : g_imask_delayed
      assign irq_mask = r_irq_mask;
    end else begin : g_imask_direct
      assign irq_mask = r_i;
    end
  endgenerate

  // Branch condition flag selection from registered state only.
  always_comb begin
    w_sel_flag = r_c;
    case (br_sel)
      2'd0:    w_sel_flag = r_c;
      2'd1:    w_sel_flag = r_z;
      2'd2:    w_sel_flag = r_v;
      default: w_sel_flag = r_n;
    endcase
  end

  assign branch_taken = (w_sel_flag == br_sense);
  assign p_push       = {r_n, r_v, 1'b1, push_brk, r_d, r_i, r_z, r_c};
  assign c_in         = r_c;
  assign bcd          = r_d;

endmodule
`default_nettype wire
